// File: rtl/risc_prog_loader.sv
// -----------------------------------------------------------------------------
// risc_prog_loader
//
// Loads a program into the RISC core's instruction memory from a framed byte
// stream and holds the core in reset until the load has been verified.
//
// Frame on the byte stream:  LEN, LEN*BYTES data bytes (LSB first per word),
// CSUM = XOR of all data bytes.
//
// Handshake: byte_valid qualifies byte_in for one cycle. There is no ready;
// the loader accepts one byte per cycle with no stalls while a frame is in
// progress (LEN/DATA/CSUM), and silently ignores byte_valid otherwise. A
// load_start in the same cycle as byte_valid wins and the byte is dropped.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   load_start        one-cycle request to (re)start a frame
//   byte_valid/byte_in stream byte
//   mem_we/mem_addr/mem_data  instruction memory write port (one-cycle strobe)
//   cpu_rst_n         active-low reset to the core (released only after a
//                     verified load)
//   busy/done/error   frame in progress / load verified / load failed
//   error_code        01 bad length, 10 checksum mismatch, 11 timeout
//   words_loaded      words written in the current or last frame
// -----------------------------------------------------------------------------
module risc_prog_loader #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 7,
    parameter int DEPTH   = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        error_code,
    output logic [7:0]        words_loaded
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_TO   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t state;
    state_t state_next;

    // Frame datapath
    logic [IDX_W-1:0]  byte_idx;
    logic [7:0]        word_cnt;
    logic [7:0]        len_reg;
    logic [7:0]        csum;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] word_reg;
    logic [DATA_W-1:0] assembled;

    // Decoded conditions
    logic       in_frame;
    logic       accept;
    logic       timeout_hit;
    logic       len_bad;
    logic       word_done;
    logic       last_word;
    logic [1:0] err_kind;

    // Next values of the registered outputs
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_data_d;
    logic              cpu_rst_n_d;
    logic              busy_d;
    logic              done_d;
    logic              error_d;
    logic [1:0]        error_code_d;
    logic [7:0]        words_loaded_d;

    assign in_frame    = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign accept      = byte_valid && !load_start && in_frame;
    // Only consulted on cycles without a byte; constant-false when disabled.
    assign timeout_hit = (TIMEOUT > 0) && (to_cnt == TO_LAST);
    assign len_bad     = (byte_in == 8'd0) || (int'(byte_in) > DEPTH);
    assign word_done   = accept && (state == S_DATA) && (byte_idx == LAST_IDX);
    assign last_word   = word_done && (word_cnt == len_reg - 8'd1);

    // Current word with the incoming byte dropped into its lane, so the
    // write on the last lane can use it directly without an extra cycle.
    always_comb begin
        assembled = word_reg;
        for (int k = 0; k < BYTES; k++) begin
            if (byte_idx == IDX_W'(k)) begin
                assembled[8*k +: 8] = byte_in;
            end
        end
    end

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        err_kind   = ERR_NONE;
        if (load_start) begin
            state_next = S_LEN;
        end else begin
            case (state)
                S_LEN: begin
                    if (byte_valid) begin
                        if (len_bad) begin
                            state_next = S_ERR;
                            err_kind   = ERR_LEN;
                        end else begin
                            state_next = S_DATA;
                        end
                    end else if (timeout_hit) begin
                        state_next = S_ERR;
                        err_kind   = ERR_TO;
                    end
                end
                S_DATA: begin
                    if (byte_valid) begin
                        if (last_word) begin
                            state_next = S_CSUM;
                        end
                    end else if (timeout_hit) begin
                        state_next = S_ERR;
                        err_kind   = ERR_TO;
                    end
                end
                S_CSUM: begin
                    if (byte_valid) begin
                        if (byte_in == csum) begin
                            state_next = S_RUN;
                        end else begin
                            state_next = S_ERR;
                            err_kind   = ERR_CSUM;
                        end
                    end else if (timeout_hit) begin
                        state_next = S_ERR;
                        err_kind   = ERR_TO;
                    end
                end
                S_IDLE, S_RUN, S_ERR: begin
                    state_next = state;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // ----------------------------------------------------------- output decode
    // Status flags follow the state being entered so they line up with the
    // state register after the edge.
    always_comb begin
        busy_d      = (state_next == S_LEN) || (state_next == S_DATA) ||
                      (state_next == S_CSUM);
        done_d      = (state_next == S_RUN);
        error_d     = (state_next == S_ERR);
        cpu_rst_n_d = (state_next == S_RUN);

        error_code_d = error_code;
        if (load_start) begin
            error_code_d = ERR_NONE;
        end else if ((state_next == S_ERR) && (state != S_ERR)) begin
            error_code_d = err_kind;
        end

        words_loaded_d = words_loaded;
        if (load_start) begin
            words_loaded_d = 8'd0;
        end else if (word_done) begin
            words_loaded_d = words_loaded + 8'd1;
        end

        mem_we_d   = word_done;
        mem_addr_d = word_done ? ADDR_W'(word_cnt) : mem_addr;
        mem_data_d = word_done ? assembled : mem_data;
    end

    // --------------------------------------------------------- output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            cpu_rst_n    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            error_code   <= ERR_NONE;
            words_loaded <= 8'd0;
        end else begin
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_data     <= mem_data_d;
            cpu_rst_n    <= cpu_rst_n_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= error_d;
            error_code   <= error_code_d;
            words_loaded <= words_loaded_d;
        end
    end

    // ---------------------------------------------------------- frame datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx <= '0;
            word_cnt <= 8'd0;
            len_reg  <= 8'd0;
            csum     <= 8'd0;
            to_cnt   <= '0;
            word_reg <= '0;
        end else if (load_start) begin
            byte_idx <= '0;
            word_cnt <= 8'd0;
            csum     <= 8'd0;
            to_cnt   <= '0;
        end else begin
            // Idle-cycle counter; it only matters while a frame is open and
            // the frame is left as soon as it reaches TO_LAST.
            if (in_frame) begin
                to_cnt <= accept ? '0 : to_cnt + TO_W'(1);
            end
            if (accept && (state == S_LEN)) begin
                len_reg <= byte_in;
            end
            if (accept && (state == S_DATA)) begin
                csum     <= csum ^ byte_in;
                word_reg <= assembled;
                if (byte_idx == LAST_IDX) begin
                    byte_idx <= '0;
                    word_cnt <= word_cnt + 8'd1;
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_risc_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_risc_prog_loader
//
// Two loaders share one byte stream: dut_a is 8-bit wide with a 16-cycle
// timeout, dut_b is 16-bit wide with the timeout disabled. Every frame is
// therefore interpreted twice; the reference model computes the expected
// writes and final status from the frame contents for either word width.
// -----------------------------------------------------------------------------
module tb_risc_prog_loader;

    logic       clk;
    logic       rst_n;
    logic       load_start;
    logic       byte_valid;
    logic [7:0] byte_in;

    logic        a_mem_we, a_cpu_rst_n, a_busy, a_done, a_error;
    logic [6:0]  a_mem_addr;
    logic [7:0]  a_mem_data;
    logic [1:0]  a_error_code;
    logic [7:0]  a_words_loaded;

    logic        b_mem_we, b_cpu_rst_n, b_busy, b_done, b_error;
    logic [6:0]  b_mem_addr;
    logic [15:0] b_mem_data;
    logic [1:0]  b_error_code;
    logic [7:0]  b_words_loaded;

    risc_prog_loader #(.DATA_W(8), .ADDR_W(7), .DEPTH(128), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .byte_valid(byte_valid), .byte_in(byte_in),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
        .cpu_rst_n(a_cpu_rst_n), .busy(a_busy), .done(a_done), .error(a_error),
        .error_code(a_error_code), .words_loaded(a_words_loaded)
    );

    risc_prog_loader #(.DATA_W(16), .ADDR_W(7), .DEPTH(128), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .byte_valid(byte_valid), .byte_in(byte_in),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
        .cpu_rst_n(b_cpu_rst_n), .busy(b_busy), .done(b_done), .error(b_error),
        .error_code(b_error_code), .words_loaded(b_words_loaded)
    );

    // Status word: {busy, done, error, cpu_rst_n, error_code, words_loaded}
    logic [13:0] a_st, b_st;
    // Everything: {mem_we, addr(8), data(16), status}
    logic [38:0] a_all, b_all;
    assign a_st  = {a_busy, a_done, a_error, a_cpu_rst_n, a_error_code, a_words_loaded};
    assign b_st  = {b_busy, b_done, b_error, b_cpu_rst_n, b_error_code, b_words_loaded};
    assign a_all = {a_mem_we, 8'(a_mem_addr), 16'(a_mem_data), a_st};
    assign b_all = {b_mem_we, 8'(b_mem_addr), b_mem_data, b_st};

    localparam logic [3:0] F_BUSY = 4'b1000;
    localparam logic [3:0] F_RUN  = 4'b0101;
    localparam logic [3:0] F_ERR  = 4'b0010;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard queues: entries are {addr(8), data(16)}
    logic [23:0] obs_a_q[$];
    logic [23:0] obs_b_q[$];
    logic [23:0] exp_a_q[$];
    logic [23:0] exp_b_q[$];
    logic [7:0]  frame_q[$];

    // ------------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_mem_we === 1'b1) obs_a_q.push_back({8'(a_mem_addr), 16'(a_mem_data)});
        if (b_mem_we === 1'b1) obs_b_q.push_back({8'(b_mem_addr), b_mem_data});
    end

    // ------------------------------------------------------------ drivers
    // All drivers are entered and left at a negedge.
    task automatic drive_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
    endtask

    task automatic do_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int gap_max);
        foreach (frame_q[i]) begin
            drive_byte(frame_q[i]);
            idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic clear_queues();
        obs_a_q.delete(); obs_b_q.delete();
        exp_a_q.delete(); exp_b_q.delete();
    endtask

    // ---------------------------------------------------- reference model
    // Interprets frame_q for a loader with nb bytes per word: expected
    // writes go to the matching expected queue, final status is returned.
    task automatic model(input int nb, output logic [13:0] st);
        int len, need, avail, wl;
        logic [15:0] word;
        logic [7:0]  x;
        len   = int'(frame_q[0]);
        avail = frame_q.size() - 1;
        need  = len * nb;
        wl    = 0;
        word  = 16'd0;
        x     = 8'd0;
        if (len == 0 || len > 128) begin
            st = {F_ERR, 2'b01, 8'd0};
            return;
        end
        for (int i = 0; i < need && i < avail; i++) begin
            x = x ^ frame_q[1+i];
            word[8*(i%nb) +: 8] = frame_q[1+i];
            if (i % nb == nb - 1) begin
                if (nb == 1) exp_a_q.push_back({8'(i/nb), word});
                else         exp_b_q.push_back({8'(i/nb), word});
                wl++;
                word = 16'd0;
            end
        end
        if (avail > need)
            st = (frame_q[1+need] == x) ? {F_RUN, 2'b00, 8'(wl)} : {F_ERR, 2'b10, 8'(wl)};
        else
            st = {F_BUSY, 2'b00, 8'(wl)};
    endtask

    // -------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        n_tests++;
        if (a_all !== 39'd0) begin n_fail++; $display("FAIL reset_a: got %h want 0", a_all); end
        n_tests++;
        if (b_all !== 39'd0) begin n_fail++; $display("FAIL reset_b: got %h want 0", b_all); end
        rst_n = 1'b1;
        idle(1);
        drive_byte(8'h05);   // ignored in IDLE
        idle(1);
        n_tests++;
        if (a_all !== 39'd0) begin n_fail++; $display("FAIL idle_ignore_a: got %h want 0", a_all); end
        n_tests++;
        if (b_all !== 39'd0) begin n_fail++; $display("FAIL idle_ignore_b: got %h want 0", b_all); end
        n_tests++;
        if (obs_a_q.size() + obs_b_q.size() != 0) begin
            n_fail++; $display("FAIL idle_writes: got %0d writes want 0", obs_a_q.size() + obs_b_q.size());
        end
    endtask

    task automatic test_basic();
        logic [7:0] d[3];
        d[0] = 8'h12; d[1] = 8'h34; d[2] = 8'h56;
        do_start();
        clear_queues();
        n_tests++;
        if (a_st !== {F_BUSY, 2'b00, 8'd0}) begin n_fail++; $display("FAIL basic_start: got %h want %h", a_st, {F_BUSY, 2'b00, 8'd0}); end
        drive_byte(8'h03);
        n_tests++;
        if (a_mem_we !== 1'b0) begin n_fail++; $display("FAIL basic_len_we: got %b want 0", a_mem_we); end
        for (int i = 0; i < 3; i++) begin
            drive_byte(d[i]);
            n_tests++;
            if ({a_mem_we, a_mem_addr, a_mem_data} !== {1'b1, 7'(i), d[i]}) begin
                n_fail++; $display("FAIL basic_write%0d: got %b/%h/%h want 1/%h/%h",
                                   i, a_mem_we, a_mem_addr, a_mem_data, 7'(i), d[i]);
            end
        end
        drive_byte(8'h70);
        n_tests++;
        if ({a_mem_we, a_st} !== {1'b0, F_RUN, 2'b00, 8'd3}) begin
            n_fail++; $display("FAIL basic_done: got %h want %h", {a_mem_we, a_st}, {1'b0, F_RUN, 2'b00, 8'd3});
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] d[3];
        d[0] = 8'h12; d[1] = 8'h34; d[2] = 8'h56;
        do_start();
        clear_queues();
        drive_byte(8'h03); drive_byte(8'h12); drive_byte(8'h34);
        drive_byte(8'h56); drive_byte(8'h71);
        idle(1);
        n_tests++;
        if (a_st !== {F_ERR, 2'b10, 8'd3}) begin n_fail++; $display("FAIL csum_status: got %h want %h", a_st, {F_ERR, 2'b10, 8'd3}); end
        n_tests++;
        if (obs_a_q.size() != 3) begin
            n_fail++; $display("FAIL csum_wcount: got %0d want 3", obs_a_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (obs_a_q[i] !== {8'(i), 8'h00, d[i]}) begin
                    n_fail++; $display("FAIL csum_write%0d: got %h want %h", i, obs_a_q[i], {8'(i), 8'h00, d[i]});
                    break;
                end
            end
        end
    endtask

    task automatic test_wide();
        do_start();
        clear_queues();
        drive_byte(8'h02);
        drive_byte(8'hCD);
        n_tests++;
        if (b_mem_we !== 1'b0) begin n_fail++; $display("FAIL wide_odd_we: got %b want 0", b_mem_we); end
        drive_byte(8'hAB);
        n_tests++;
        if ({b_mem_we, b_mem_addr, b_mem_data} !== {1'b1, 7'd0, 16'hABCD}) begin
            n_fail++; $display("FAIL wide_w0: got %b/%h/%h want 1/00/abcd", b_mem_we, b_mem_addr, b_mem_data);
        end
        drive_byte(8'h34);
        n_tests++;
        if (b_mem_we !== 1'b0) begin n_fail++; $display("FAIL wide_odd_we2: got %b want 0", b_mem_we); end
        drive_byte(8'h12);
        n_tests++;
        if ({b_mem_we, b_mem_addr, b_mem_data} !== {1'b1, 7'd1, 16'h1234}) begin
            n_fail++; $display("FAIL wide_w1: got %b/%h/%h want 1/01/1234", b_mem_we, b_mem_addr, b_mem_data);
        end
        drive_byte(8'h40);
        idle(1);
        n_tests++;
        if (b_st !== {F_RUN, 2'b00, 8'd2} || obs_b_q.size() != 2) begin
            n_fail++; $display("FAIL wide_done: got %h/%0d writes want %h/2", b_st, obs_b_q.size(), {F_RUN, 2'b00, 8'd2});
        end
        // The 8-bit loader sees LEN=2, data CD,AB, checksum 34 != 66.
        n_tests++;
        if (a_st !== {F_ERR, 2'b10, 8'd2}) begin n_fail++; $display("FAIL wide_a_view: got %h want %h", a_st, {F_ERR, 2'b10, 8'd2}); end
    endtask

    task automatic test_bad_len();
        logic [7:0] lens[2];
        lens[0] = 8'h00; lens[1] = 8'h81;
        for (int i = 0; i < 2; i++) begin
            do_start();
            clear_queues();
            drive_byte(lens[i]);
            drive_byte(8'h11);
            idle(2);
            n_tests++;
            if (a_st !== {F_ERR, 2'b01, 8'd0} || b_st !== {F_ERR, 2'b01, 8'd0}) begin
                n_fail++; $display("FAIL bad_len_%h: got %h/%h want %h", lens[i], a_st, b_st, {F_ERR, 2'b01, 8'd0});
            end
            n_tests++;
            if (obs_a_q.size() + obs_b_q.size() != 0) begin
                n_fail++; $display("FAIL bad_len_writes_%h: got %0d want 0", lens[i], obs_a_q.size() + obs_b_q.size());
            end
        end
    endtask

    task automatic test_timeout();
        do_start();
        clear_queues();
        drive_byte(8'h03);
        drive_byte(8'h12);
        idle(15);
        n_tests++;
        if (a_st !== {F_BUSY, 2'b00, 8'd1}) begin n_fail++; $display("FAIL to_early: got %h want %h", a_st, {F_BUSY, 2'b00, 8'd1}); end
        idle(1);
        n_tests++;
        if (a_st !== {F_ERR, 2'b11, 8'd1}) begin n_fail++; $display("FAIL to_fire: got %h want %h", a_st, {F_ERR, 2'b11, 8'd1}); end
        n_tests++;
        if (obs_a_q.size() != 1 || obs_a_q[0] !== 24'h000012) begin
            n_fail++; $display("FAIL to_writes: got %0d writes want 1 (00/12)", obs_a_q.size());
        end
        n_tests++;
        if (b_st !== {F_BUSY, 2'b00, 8'd0}) begin n_fail++; $display("FAIL to_disabled: got %h want %h", b_st, {F_BUSY, 2'b00, 8'd0}); end
        do_start();
        n_tests++;
        if (a_st !== {F_BUSY, 2'b00, 8'd0}) begin n_fail++; $display("FAIL to_restart: got %h want %h", a_st, {F_BUSY, 2'b00, 8'd0}); end
        drive_byte(8'h01);
        drive_byte(8'hAA);
        n_tests++;
        if ({a_mem_we, a_mem_addr, a_mem_data} !== {1'b1, 7'd0, 8'hAA}) begin
            n_fail++; $display("FAIL to_reload_w: got %b/%h/%h want 1/00/aa", a_mem_we, a_mem_addr, a_mem_data);
        end
        drive_byte(8'hAA);
        n_tests++;
        if (a_st !== {F_RUN, 2'b00, 8'd1}) begin n_fail++; $display("FAIL to_reload_done: got %h want %h", a_st, {F_RUN, 2'b00, 8'd1}); end
    endtask

    task automatic test_restart();
        do_start();
        clear_queues();
        drive_byte(8'h03);
        drive_byte(8'h12);
        // Restart with a byte in the same cycle: the byte must be dropped.
        load_start = 1'b1; byte_valid = 1'b1; byte_in = 8'h99;
        @(negedge clk);
        load_start = 1'b0; byte_valid = 1'b0;
        n_tests++;
        if ({a_mem_we, a_st} !== {1'b0, F_BUSY, 2'b00, 8'd0}) begin
            n_fail++; $display("FAIL restart_len: got %h want %h", {a_mem_we, a_st}, {1'b0, F_BUSY, 2'b00, 8'd0});
        end
        drive_byte(8'h02); drive_byte(8'h55); drive_byte(8'h66); drive_byte(8'h33);
        idle(1);
        n_tests++;
        if (a_st !== {F_RUN, 2'b00, 8'd2}) begin n_fail++; $display("FAIL restart_done: got %h want %h", a_st, {F_RUN, 2'b00, 8'd2}); end
        exp_a_q.push_back(24'h000012);
        exp_a_q.push_back(24'h000055);
        exp_a_q.push_back(24'h010066);
        n_tests++;
        if (obs_a_q.size() != exp_a_q.size()) begin
            n_fail++; $display("FAIL restart_wcount: got %0d want %0d", obs_a_q.size(), exp_a_q.size());
        end else begin
            foreach (exp_a_q[i]) begin
                if (obs_a_q[i] !== exp_a_q[i]) begin
                    n_fail++; $display("FAIL restart_write%0d: got %h want %h", i, obs_a_q[i], exp_a_q[i]);
                    break;
                end
            end
        end
        // Reset in the middle of a frame, together with a byte that would
        // otherwise complete a word.
        do_start();
        drive_byte(8'h07); drive_byte(8'h21); drive_byte(8'h22);
        rst_n = 1'b0; byte_valid = 1'b1; byte_in = 8'h23;
        @(negedge clk);
        byte_valid = 1'b0;
        n_tests++;
        if (a_all !== 39'd0 || b_all !== 39'd0) begin
            n_fail++; $display("FAIL midframe_reset: got %h/%h want 0/0", a_all, b_all);
        end
        rst_n = 1'b1;
        drive_byte(8'h24);
        idle(1);
        n_tests++;
        if (a_all !== 39'd0 || b_all !== 39'd0) begin
            n_fail++; $display("FAIL after_reset_idle: got %h/%h want 0/0", a_all, b_all);
        end
    endtask

    task automatic test_random(input int n_frames);
        logic [13:0] st_a, st_b;
        int len, nb_t, kind, gap;
        logic [7:0] x, b;
        for (int f = 0; f < n_frames; f++) begin
            nb_t = $urandom_range(1, 2);
            kind = $urandom_range(0, 9);
            gap  = (f < 3) ? 0 : 3;
            if (kind == 0)      len = 0;
            else if (kind == 1) len = $urandom_range(129, 255);
            else                len = $urandom_range(1, 6);
            frame_q.delete();
            frame_q.push_back(8'(len));
            x = 8'd0;
            if (len >= 1 && len <= 128) begin
                for (int i = 0; i < len * nb_t; i++) begin
                    b = 8'($urandom);
                    x = x ^ b;
                    frame_q.push_back(b);
                end
                frame_q.push_back((kind == 2) ? (x ^ 8'($urandom_range(1, 255))) : x);
            end else begin
                frame_q.push_back(8'($urandom));
            end
            do_start();
            clear_queues();
            model(1, st_a);
            model(2, st_b);
            send_frame(gap);
            idle(2);
            n_tests++;
            if (a_st !== st_a) begin n_fail++; $display("FAIL rand%0d_status_a: got %h want %h", f, a_st, st_a); end
            n_tests++;
            if (b_st !== st_b) begin n_fail++; $display("FAIL rand%0d_status_b: got %h want %h", f, b_st, st_b); end
            n_tests++;
            if (obs_a_q.size() != exp_a_q.size()) begin
                n_fail++; $display("FAIL rand%0d_wcount_a: got %0d want %0d", f, obs_a_q.size(), exp_a_q.size());
            end else begin
                foreach (exp_a_q[i]) begin
                    if (obs_a_q[i] !== exp_a_q[i]) begin
                        n_fail++; $display("FAIL rand%0d_write_a%0d: got %h want %h", f, i, obs_a_q[i], exp_a_q[i]);
                        break;
                    end
                end
            end
            n_tests++;
            if (obs_b_q.size() != exp_b_q.size()) begin
                n_fail++; $display("FAIL rand%0d_wcount_b: got %0d want %0d", f, obs_b_q.size(), exp_b_q.size());
            end else begin
                foreach (exp_b_q[i]) begin
                    if (obs_b_q[i] !== exp_b_q[i]) begin
                        n_fail++; $display("FAIL rand%0d_write_b%0d: got %h want %h", f, i, obs_b_q[i], exp_b_q[i]);
                        break;
                    end
                end
            end
        end
    endtask

    // --------------------------------------------------------------- main
    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_bad_csum();
        test_wide();
        test_bad_len();
        test_timeout();
        test_restart();
        test_random(24);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
